// File: rtl/note_seq_ctrl.sv
// -----------------------------------------------------------------------------
// note_seq_ctrl
//   Step sequencer for a tone generator. Holds a C_STEPS-entry pattern memory
//   (18-bit entries: [14:0] pulse_n, [16:15] wave mode, [17] rest) and plays
//   entries 0..LAST_i in a loop. Each step lasts TEMPO_i enabled cycles; the
//   note gate is high for the first GATE_LEN_i enabled cycles of the step.
//
// Ports
//   CK_i         clock, rising edge
//   RST_i        synchronous active-high reset (clears state and pattern)
//   EN_CK_i      clock enable; sequencing only moves on enabled cycles
//   START_i      start / restart play at step 0
//   STOP_i       stop play (wins over START_i)
//   TEMPO_i      step period in enabled cycles (0 behaves as 1)
//   GATE_LEN_i   gate-high length in enabled cycles
//   LAST_i       index of the last step in the loop
//   WR_i         pattern write strobe (not gated by EN_CK_i)
//   WR_ADR_i     pattern write address
//   WR_DAT_i     pattern write data
//   PULSE_N_o    pulse_n of the current step
//   WAVE_MODE_o  wave mode of the current step
//   GATE_o       note-on gate
//   STEP_o       index of the current step
//   STEP_STB_o   one-cycle strobe on every step load
//   BUSY_o       high whenever the sequencer is not idle
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | not playing; outputs hold last step, gate low
// GATE   | inside a step, gate portion (gate = ~rest)
// GAP    | inside a step, after the gate has dropped
// -----------------------------------------------------------------------------
module note_seq_ctrl #(
    parameter int  C_STEPS  = 8,
    parameter int  C_TIM_W  = 24,
    localparam int C_STEP_W = $clog2(C_STEPS)
) (
    input  logic                CK_i,
    input  logic                RST_i,
    input  tri1                 EN_CK_i,
    input  logic                START_i,
    input  logic                STOP_i,
    input  logic [C_TIM_W-1:0]  TEMPO_i,
    input  logic [C_TIM_W-1:0]  GATE_LEN_i,
    input  logic [C_STEP_W-1:0] LAST_i,
    input  logic                WR_i,
    input  logic [C_STEP_W-1:0] WR_ADR_i,
    input  logic [17:0]         WR_DAT_i,
    output logic [14:0]         PULSE_N_o,
    output logic [1:0]          WAVE_MODE_o,
    output logic                GATE_o,
    output logic [C_STEP_W-1:0] STEP_o,
    output logic                STEP_STB_o,
    output logic                BUSY_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATE,
        S_GAP
    } state_t;

    state_t               state;
    logic [C_TIM_W-1:0]   cnt;
    logic [17:0]          mem [C_STEPS];

    logic [C_TIM_W-1:0]   tempo_eff;
    logic [C_TIM_W-1:0]   tempo_m1;
    logic [C_TIM_W-1:0]   gate_m1;
    logic                 gate_zero;
    logic                 end_of_step;
    logic                 gate_end;
    logic                 do_start;
    logic [C_STEP_W-1:0]  step_nxt;
    logic [C_STEP_W-1:0]  load_adr;
    logic [17:0]          load_dat;

    always_comb begin
        tempo_eff   = (TEMPO_i == '0) ? C_TIM_W'(1) : TEMPO_i;
        tempo_m1    = tempo_eff - C_TIM_W'(1);
        gate_m1     = GATE_LEN_i - C_TIM_W'(1);
        gate_zero   = (GATE_LEN_i == '0);
        end_of_step = (state != S_IDLE) && (cnt == tempo_m1);
        // Legato (gate length covers the whole step) never drops the gate.
        gate_end    = (state == S_GATE) && !gate_zero && (cnt == gate_m1)
                      && (GATE_LEN_i < tempo_eff);
        // ">=" also catches LAST_i having been lowered below the current step.
        step_nxt    = (STEP_o >= LAST_i) ? '0 : STEP_o + C_STEP_W'(1);
        do_start    = START_i && !STOP_i;
        load_adr    = do_start ? '0 : step_nxt;
        // Write-first: a write to the entry being loaded is seen by the load.
        load_dat    = (WR_i && (WR_ADR_i == load_adr)) ? WR_DAT_i : mem[load_adr];
    end

    assign BUSY_o = (state != S_IDLE);

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            for (int i = 0; i < C_STEPS; i++) begin
                mem[i] <= '0;
            end
            PULSE_N_o   <= '0;
            WAVE_MODE_o <= '0;
            GATE_o      <= 1'b0;
            STEP_o      <= '0;
            STEP_STB_o  <= 1'b0;
        end else begin
            STEP_STB_o <= 1'b0;

            if (WR_i) begin
                mem[WR_ADR_i] <= WR_DAT_i;
            end

            if (EN_CK_i) begin
                if (STOP_i) begin
                    state  <= S_IDLE;
                    GATE_o <= 1'b0;
                end else if (START_i || end_of_step) begin
                    STEP_o      <= load_adr;
                    PULSE_N_o   <= load_dat[14:0];
                    WAVE_MODE_o <= load_dat[16:15];
                    GATE_o      <= !load_dat[17] && !gate_zero;
                    STEP_STB_o  <= 1'b1;
                    cnt         <= '0;
                    state       <= gate_zero ? S_GAP : S_GATE;
                end else if (state != S_IDLE) begin
                    cnt <= cnt + C_TIM_W'(1);
                    if (gate_end) begin
                        GATE_o <= 1'b0;
                        state  <= S_GAP;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_note_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_note_seq_ctrl
//   Directed bench for note_seq_ctrl: a cycle-by-cycle vector table with a
//   short tempo, then hand-written sequences for looping, rest/legato, enable
//   gating, reset mid-play and the tempo / gate / loop-length boundaries.
// -----------------------------------------------------------------------------
module tb_note_seq_ctrl;

    localparam int SW = 3;
    localparam int TW = 24;

    logic          CK_i = 1'b0;
    logic          RST_i;
    logic          EN_CK_i;
    logic          START_i;
    logic          STOP_i;
    logic [TW-1:0] TEMPO_i;
    logic [TW-1:0] GATE_LEN_i;
    logic [SW-1:0] LAST_i;
    logic          WR_i;
    logic [SW-1:0] WR_ADR_i;
    logic [17:0]   WR_DAT_i;
    logic [14:0]   PULSE_N_o;
    logic [1:0]    WAVE_MODE_o;
    logic          GATE_o;
    logic [SW-1:0] STEP_o;
    logic          STEP_STB_o;
    logic          BUSY_o;

    note_seq_ctrl #(.C_STEPS(8), .C_TIM_W(TW)) dut (
        .CK_i        (CK_i),
        .RST_i       (RST_i),
        .EN_CK_i     (EN_CK_i),
        .START_i     (START_i),
        .STOP_i      (STOP_i),
        .TEMPO_i     (TEMPO_i),
        .GATE_LEN_i  (GATE_LEN_i),
        .LAST_i      (LAST_i),
        .WR_i        (WR_i),
        .WR_ADR_i    (WR_ADR_i),
        .WR_DAT_i    (WR_DAT_i),
        .PULSE_N_o   (PULSE_N_o),
        .WAVE_MODE_o (WAVE_MODE_o),
        .GATE_o      (GATE_o),
        .STEP_o      (STEP_o),
        .STEP_STB_o  (STEP_STB_o),
        .BUSY_o      (BUSY_o)
    );

    always #5 CK_i = ~CK_i;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        start;
        logic        stop;
        logic        wr;
        logic        en;
        logic [2:0]  adr;
        logic [17:0] dat;
        logic [14:0] p;
        logic [1:0]  w;
        logic [2:0]  s;
        logic        g;
        logic        stb;
        logic        busy;
    } vec_t;

    vec_t tbl [18];

    task automatic tick();
        @(posedge CK_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int p, input int w, input int s,
                           input int g, input int stb, input int b);
        chk({tag, " pulse"}, 32'(PULSE_N_o),   32'(p));
        chk({tag, " wave"},  32'(WAVE_MODE_o), 32'(w));
        chk({tag, " step"},  32'(STEP_o),      32'(s));
        chk({tag, " gate"},  32'(GATE_o),      32'(g));
        chk({tag, " stb"},   32'(STEP_STB_o),  32'(stb));
        chk({tag, " busy"},  32'(BUSY_o),      32'(b));
    endtask

    task automatic wr_entry(input int adr, input bit rest, input int wave, input int pn);
        WR_i     = 1'b1;
        WR_ADR_i = SW'(adr);
        WR_DAT_i = {rest, 2'(wave), 15'(pn)};
        tick();
        WR_i     = 1'b0;
    endtask

    task automatic do_reset();
        RST_i = 1'b1;
        tick();
        RST_i = 1'b0;
    endtask

    task automatic start_play();
        START_i = 1'b1;
        tick();
        START_i = 1'b0;
    endtask

    task automatic load_basic(input bit rest1);
        for (int k = 0; k < 4; k++) begin
            wr_entry(k, (k == 1) && rest1, 0, 100 * (k + 1));
        end
    endtask

    initial begin
        int exp_step;
        int exp_pulse;

        RST_i      = 1'b1;
        EN_CK_i    = 1'b1;
        START_i    = 1'b0;
        STOP_i     = 1'b0;
        WR_i       = 1'b0;
        WR_ADR_i   = '0;
        WR_DAT_i   = '0;
        TEMPO_i    = 24'd3;
        GATE_LEN_i = 24'd2;
        LAST_i     = 3'd2;
        tick();
        tick();
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        RST_i = 1'b0;

        // Vector table: TEMPO=3, GATE_LEN=2, LAST=2.
        //            start stop wr en adr  dat                     p    w  s  g stb busy
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, {1'b0, 2'd1, 15'd100}, 15'd0,   2'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, {1'b1, 2'd2, 15'd200}, 15'd0,   2'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd2, {1'b0, 2'd3, 15'd300}, 15'd0,   2'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd100, 2'd1, 3'd0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd100, 2'd1, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd100, 2'd1, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd200, 2'd2, 3'd1, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd200, 2'd2, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd200, 2'd2, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd300, 2'd3, 3'd2, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 18'd0,                 15'd300, 2'd3, 3'd2, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd300, 2'd3, 3'd2, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd300, 2'd3, 3'd2, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd0, {1'b0, 2'd0, 15'd555}, 15'd555, 2'd0, 3'd0, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd555, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 18'd0,                 15'd555, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd555, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 18'd0,                 15'd555, 2'd0, 3'd0, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 18; i++) begin
            START_i  = tbl[i].start;
            STOP_i   = tbl[i].stop;
            WR_i     = tbl[i].wr;
            EN_CK_i  = tbl[i].en;
            WR_ADR_i = tbl[i].adr;
            WR_DAT_i = tbl[i].dat;
            tick();
            chk_out($sformatf("tbl%0d", i), int'(tbl[i].p), int'(tbl[i].w), int'(tbl[i].s),
                    int'(tbl[i].g), int'(tbl[i].stb), int'(tbl[i].busy));
        end
        START_i = 1'b0;
        STOP_i  = 1'b0;
        WR_i    = 1'b0;
        EN_CK_i = 1'b1;

        // Basic loop, plus a write to the playing entry that shows only at its next load.
        do_reset();
        load_basic(1'b0);
        TEMPO_i    = 24'd10;
        GATE_LEN_i = 24'd6;
        LAST_i     = 3'd3;
        start_play();
        for (int i = 0; i < 50; i++) begin
            if (i > 0) begin
                if (i == 3) begin
                    WR_i     = 1'b1;
                    WR_ADR_i = 3'd0;
                    WR_DAT_i = {1'b0, 2'd0, 15'd111};
                end
                tick();
                WR_i = 1'b0;
            end
            exp_step  = (i / 10) % 4;
            exp_pulse = (exp_step == 0 && i >= 40) ? 111 : 100 * (exp_step + 1);
            chk($sformatf("loop stb c%0d", i),   32'(STEP_STB_o), 32'(i % 10 == 0));
            chk($sformatf("loop gate c%0d", i),  32'(GATE_o),     32'(i % 10 < 6));
            chk($sformatf("loop step c%0d", i),  32'(STEP_o),     32'(exp_step));
            chk($sformatf("loop pulse c%0d", i), 32'(PULSE_N_o),  32'(exp_pulse));
        end

        // Rest on step 1, legato elsewhere.
        do_reset();
        load_basic(1'b1);
        GATE_LEN_i = 24'd10;
        start_play();
        for (int i = 0; i < 41; i++) begin
            if (i > 0) tick();
            exp_step = (i / 10) % 4;
            chk($sformatf("legato gate c%0d", i), 32'(GATE_o), 32'(exp_step != 1));
            chk($sformatf("legato step c%0d", i), 32'(STEP_o), 32'(exp_step));
        end

        // Enable toggling: step period doubles; a write while disabled still lands.
        do_reset();
        load_basic(1'b0);
        GATE_LEN_i = 24'd6;
        start_play();
        for (int i = 1; i <= 70; i++) begin
            EN_CK_i = (i % 2 == 0);
            if (i == 5) begin
                WR_i     = 1'b1;
                WR_ADR_i = 3'd3;
                WR_DAT_i = {1'b0, 2'd2, 15'd999};
            end
            tick();
            WR_i = 1'b0;
            chk($sformatf("en stb c%0d", i), 32'(STEP_STB_o), 32'(i % 20 == 0));
            if (i == 60) begin
                chk("en step3 step",  32'(STEP_o),    32'd3);
                chk("en step3 pulse", 32'(PULSE_N_o), 32'd999);
            end
        end
        EN_CK_i = 1'b1;

        // Reset mid-play (step 2) with a simultaneous write that must be dropped.
        do_reset();
        load_basic(1'b0);
        start_play();
        for (int i = 1; i <= 23; i++) tick();
        chk("midrst pre step", 32'(STEP_o), 32'd2);
        RST_i    = 1'b1;
        WR_i     = 1'b1;
        WR_ADR_i = 3'd0;
        WR_DAT_i = {1'b0, 2'd1, 15'd777};
        tick();
        RST_i = 1'b0;
        WR_i  = 1'b0;
        chk_out("midrst", 0, 0, 0, 0, 0, 0);
        start_play();
        chk_out("midrst start", 0, 0, 0, 1, 1, 1);

        // TEMPO=0: one step per enabled cycle.
        do_reset();
        load_basic(1'b0);
        TEMPO_i = 24'd0;
        start_play();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk($sformatf("t0 step c%0d", i), 32'(STEP_o),     32'(i % 4));
            chk($sformatf("t0 stb c%0d", i),  32'(STEP_STB_o), 32'd1);
        end

        // GATE_LEN=0: gate never rises, steps still advance.
        STOP_i = 1'b1;
        tick();
        STOP_i     = 1'b0;
        TEMPO_i    = 24'd3;
        GATE_LEN_i = 24'd0;
        start_play();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            chk($sformatf("gl0 gate c%0d", i), 32'(GATE_o),     32'd0);
            chk($sformatf("gl0 stb c%0d", i),  32'(STEP_STB_o), 32'(i % 3 == 0));
            chk($sformatf("gl0 busy c%0d", i), 32'(BUSY_o),     32'd1);
        end

        // LAST lowered from 3 to 1 while at step 2: next step wraps to 0.
        STOP_i = 1'b1;
        tick();
        STOP_i     = 1'b0;
        TEMPO_i    = 24'd10;
        GATE_LEN_i = 24'd6;
        LAST_i     = 3'd3;
        start_play();
        for (int i = 1; i <= 35; i++) begin
            if (i == 22) LAST_i = 3'd1;
            tick();
            exp_step = (i < 20) ? (i / 10) : ((i < 30) ? 2 : 0);
            chk($sformatf("last step c%0d", i), 32'(STEP_o), 32'(exp_step));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/note_seq_ctrl.md
NOTE_SEQ_CTRL -- requirements
Module: note_seq_ctrl

Interface
REQ-001 SHALL have parameter C_STEPS, default 8, number of pattern entries (power of 2); C_STEP_W = log2(C_STEPS).
REQ-002 SHALL have parameter C_TIM_W, default 24, width of the tempo and gate-length counters.
REQ-003 SHALL have port CK_i  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port RST_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port EN_CK_i  input  1  clock enable (tri1); sequencing advances only on enabled cycles.
REQ-006 SHALL have port START_i  input  1  single-cycle pulse that starts or restarts play at step 0.
REQ-007 SHALL have port STOP_i  input  1  single-cycle pulse that stops play.
REQ-008 SHALL have port TEMPO_i  input  C_TIM_W  step period, in enabled cycles.
REQ-009 SHALL have port GATE_LEN_i  input  C_TIM_W  gate-high duration, in enabled cycles.
REQ-010 SHALL have port LAST_i  input  C_STEP_W  index of the last step in the loop.
REQ-011 SHALL have port WR_i  input  1  pattern write strobe.
REQ-012 SHALL have port WR_ADR_i  input  C_STEP_W  pattern write address.
REQ-013 SHALL have port WR_DAT_i  input  18  entry: [14:0] pulse_n, [16:15] wave mode, [17] rest.
REQ-014 SHALL have port PULSE_N_o  output  15  oscillator pulse_n for the current step.
REQ-015 SHALL have port WAVE_MODE_o  output  2  wave mode for the current step.
REQ-016 SHALL have port GATE_O  output  1  note-on gate, named GATE_o.
REQ-017 SHALL have port STEP_o  output  C_STEP_W  index of the current step.
REQ-018 SHALL have port STEP_STB_o  output  1  one-cycle pulse on each step load.
REQ-019 SHALL have port BUSY_o  output  1  high whenever the state is not IDLE.

Function
REQ-020 SHALL implement the states IDLE, GATE and GAP, together with a pattern memory of C_STEPS x 18 bits and a step-time counter CNT.
REQ-021 SHALL accept pattern writes on every WR_i cycle, independent of EN_CK_i and of the state.
REQ-022 SHALL freeze the state, CNT and all outputs except STEP_STB_o on cycles where EN_CK_i is low; STEP_STB_o SHALL be 0 on those cycles.
REQ-023 SHALL perform a step load as follows: STEP_o, PULSE_N_o and WAVE_MODE_o take the addressed entry, CNT is cleared, STEP_STB_o is 1 for one cycle, and GATE_o = ~rest (forced to 0 if GATE_LEN_i = 0).
REQ-024 SHALL, when START_i is sampled on an enabled cycle in any state, step-load entry 0 with outputs visible on the next cycle, and move to GATE (or to GAP if GATE_LEN_i = 0).
REQ-025 SHALL, in GATE or GAP, increment CNT on each enabled cycle.
REQ-026 SHALL, in GATE when CNT = GATE_LEN_i-1 and GATE_LEN_i < TEMPO_i, clear GATE_o and move to GAP.
REQ-027 SHALL, in GATE or GAP when CNT = TEMPO_i-1, step-load entry (STEP_o = LAST_i ? 0 : STEP_o+1) and enter GATE; this end-of-step transition SHALL take priority over REQ-026.
REQ-028 SHALL treat TEMPO_i = 0 as 1.
REQ-029 SHALL hold GATE_o high for the whole step when GATE_LEN_i >= TEMPO_i (legato, GAP skipped); the gate SHALL still re-evaluate rest at each load.
REQ-030 SHALL, if STEP_o > LAST_i at advance time (LAST_i lowered during play), wrap to step 0.
REQ-031 SHALL, when STOP_i is sampled on an enabled cycle, enter IDLE with GATE_o = 0 on the next cycle; PULSE_N_o, WAVE_MODE_o and STEP_o SHALL hold.
REQ-032 SHALL give STOP_i priority over START_i when both are asserted in the same cycle.
REQ-033 SHALL use write-first behaviour when a write and a step load target the same address in the same cycle: the load takes WR_DAT_i.
REQ-034 SHALL make a write to the currently playing entry affect outputs only at that entry's next load.
REQ-035 SHALL sample TEMPO_i and GATE_LEN_i live; a change mid-step SHALL apply to the CNT compares from the next cycle.

Reset
REQ-036 SHALL, on RST_i = 1 at a clock edge regardless of EN_CK_i, enter IDLE and clear CNT and all pattern entries to 0.
REQ-037 SHALL reset all outputs to 0: PULSE_N_o, WAVE_MODE_o, GATE_o, STEP_o, STEP_STB_o and BUSY_o.
REQ-038 SHALL, when reset is applied mid-play, have GATE_o = 0 on the following cycle, and SHALL ignore writes in the same cycle as reset.

Verification
REQ-039 SHALL verify basic loop: entries 0..3 = pulse_n 100,200,300,400; LAST_i=3, TEMPO_i=10, GATE_LEN_i=6, EN_CK_i=1; START -> STEP_STB_o every 10 cycles; STEP_o sequence 0,1,2,3,0; GATE_o high 6 cycles and low 4 cycles per step.
REQ-040 SHALL verify rest and legato: entry 1 rest=1 -> GATE_o stays 0 throughout step 1; GATE_LEN_i=10 with TEMPO_i=10 -> GATE_o high for the whole step (low only on rest steps).
REQ-041 SHALL verify simultaneous events: START and STOP in the same cycle -> IDLE, BUSY_o=0; WR to address 2 in the step-2 load cycle -> PULSE_N_o = new data.
REQ-042 SHALL verify enable gating: EN_CK_i toggling 1/0 -> step period = 20 clocks for TEMPO_i=10; writes during EN_CK_i=0 land in memory.
REQ-043 SHALL verify reset mid-play: RST_i pulse at step 2 -> next cycle all outputs 0; START -> PULSE_N_o = 0 (memory cleared).
REQ-044 SHALL verify the boundaries: TEMPO_i=0 -> one step per enabled cycle; GATE_LEN_i=0 -> GATE_o never 1; LAST_i lowered from 3 to 1 while at step 2 -> next step 0.
